// File: rtl/rhs_spi_responder.sv
// -----------------------------------------------------------------------------
// rhs_spi_responder
//   32-bit SPI target that stands in for an RHS headstage. It captures each
//   command frame from MOSI and returns a host-queued response word on MISO in
//   the same frame. All SPI pins are oversampled in the i_clk domain, and all
//   four SPI modes are supported.
//
// Ports
//   i_clk, i_reset         system clock, synchronous active-high reset
//   i_spi_mode[1:0]        {CPOL, CPHA}, latched when a frame starts
//   i_cs_n, i_sclk, i_mosi SPI pins, asynchronous to i_clk
//   o_miso, o_miso_oe      registered data out and its enable (frame active)
//   i_tx_data, i_tx_valid  response word for the next frame
//   o_tx_ready             response hold register is empty
//   o_rx_data, o_rx_valid  last good command word, 1-cycle update pulse
//   o_rx_error             1-cycle pulse when a frame was not 32 bits long
//   o_busy                 frame in progress
//   o_frame_count[15:0]    number of good frames, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module rhs_spi_responder #(
    parameter logic [31:0] DEFAULT_RESP = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_spi_mode,
    input  logic        i_cs_n,
    input  logic        i_sclk,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    input  logic [31:0] i_tx_data,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    output logic [31:0] o_rx_data,
    output logic        o_rx_valid,
    output logic        o_rx_error,
    output logic        o_busy,
    output logic [15:0] o_frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Synchronizer chains: meta -> sync -> prev (prev only for edge detection)
    logic        r_cs_meta, r_cs_sync, r_cs_prev;
    logic        r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic        r_mosi_meta, r_mosi_sync;
    // Fills with ones after reset; r_flush[1] means r_cs_sync now carries a
    // pin value rather than its reset value.
    logic [1:0]  r_flush;

    state_t      r_state, w_next_state;

    logic        r_armed;
    logic [1:0]  r_mode;
    logic [31:0] r_hold;
    logic        r_full;
    logic [31:0] r_tx_shift;
    logic [31:0] r_rx_shift;
    logic [5:0]  r_bit_cnt;
    logic        r_overrun;
    logic        r_miso;
    logic        r_miso_oe;
    logic        r_busy;
    logic [31:0] r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_error;
    logic [15:0] r_frame_count;

    logic        w_cs_fall, w_cs_rise;
    logic        w_sclk_rise, w_sclk_fall;
    logic        w_lead_edge, w_trail_edge;
    logic        w_sample_edge, w_shift_edge;
    logic        w_start, w_end, w_done;
    logic        w_sample, w_shift;
    logic        w_frame_good;
    logic [31:0] w_word;

    // Pin synchronizers; cs_n resets to its idle (high) level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_flush     <= 2'b00;
        end else begin
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_flush     <= {r_flush[0], 1'b1};
        end
    end

    assign w_cs_fall   = ~r_cs_sync &  r_cs_prev;
    assign w_cs_rise   =  r_cs_sync & ~r_cs_prev;
    assign w_sclk_rise =  r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync &  r_sclk_prev;

    // Leading edge is rising for CPOL=0 and falling for CPOL=1; CPHA picks
    // whether the leading edge samples (CPHA=0) or shifts (CPHA=1).
    assign w_lead_edge   = r_mode[1] ? w_sclk_fall : w_sclk_rise;
    assign w_trail_edge  = r_mode[1] ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = r_mode[0] ? w_trail_edge : w_lead_edge;
    assign w_shift_edge  = r_mode[0] ? w_lead_edge  : w_trail_edge;

    assign w_word       = r_full ? r_hold : DEFAULT_RESP;
    assign w_frame_good = (r_bit_cnt == 6'd32) && !r_overrun;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle strobes; a cs_n rise beats a same-cycle sclk edge
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_done       = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_next_state = ST_ACTIVE;
                    w_start      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_next_state = ST_FINISH;
                    w_end        = 1'b1;
                end else begin
                    w_next_state = ST_ACTIVE;
                    w_sample     = w_sample_edge;
                    w_shift      = w_shift_edge;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
                w_done       = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Response hold register and the arming flag for cs_n falls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold  <= 32'h0000_0000;
            r_full  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            // Write and frame-start clear never coincide: write needs an empty
            // hold, the clear only matters when it is full.
            if (i_tx_valid && !r_full) begin
                r_hold <= i_tx_data;
                r_full <= 1'b1;
            end else if (w_start) begin
                r_full <= 1'b0;
            end else begin
                r_full <= r_full;
            end
            // Only arm once cs_n has been seen high through a refilled chain,
            // so a cs_n held low across reset cannot start a partial frame.
            if (w_start) begin
                r_armed <= 1'b0;
            end else if (r_flush[1] && r_cs_sync) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    // Frame datapath: shift registers, bit counter, MISO and status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode        <= 2'b00;
            r_tx_shift    <= 32'h0000_0000;
            r_rx_shift    <= 32'h0000_0000;
            r_bit_cnt     <= 6'd0;
            r_overrun     <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_rx_data     <= 32'h0000_0000;
            r_rx_valid    <= 1'b0;
            r_rx_error    <= 1'b0;
            r_frame_count <= 16'h0000;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
            if (w_start) begin
                r_mode    <= i_spi_mode;
                r_bit_cnt <= 6'd0;
                r_overrun <= 1'b0;
                r_busy    <= 1'b1;
                r_miso_oe <= 1'b1;
                // CPHA=0 must present bit 31 before the first (sampling) edge
                if (!i_spi_mode[0]) begin
                    r_miso     <= w_word[31];
                    r_tx_shift <= {w_word[30:0], 1'b0};
                end else begin
                    r_miso     <= 1'b0;
                    r_tx_shift <= w_word;
                end
            end
            if (w_sample) begin
                if (r_bit_cnt < 6'd32) begin
                    r_rx_shift <= {r_rx_shift[30:0], r_mosi_sync};
                    r_bit_cnt  <= r_bit_cnt + 6'd1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end
            if (w_shift) begin
                r_miso     <= r_tx_shift[31];
                r_tx_shift <= {r_tx_shift[30:0], 1'b0};
            end
            if (w_end) begin
                r_busy    <= 1'b0;
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
            end
            if (w_done) begin
                if (w_frame_good) begin
                    r_rx_data     <= r_rx_shift;
                    r_rx_valid    <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_rx_error    <= 1'b1;
                end
            end
        end
    end

    assign o_miso        = r_miso;
    assign o_miso_oe     = r_miso_oe;
    assign o_tx_ready    = ~r_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_rx_error    = r_rx_error;
    assign o_busy        = r_busy;
    assign o_frame_count = r_frame_count;

endmodule
